// File: rtl/steer_quad_ctrl.sv
// Dual-player steering scheduler: digital left/right to ramped 2-bit quadrature.
// One prescaler is shared; player 1 is serviced on the tick, player 2 on the next enabled cycle.
module steer_quad_ctrl #(
    parameter int unsigned CLKDIV     = 22500,
    parameter int unsigned RAMP_STEPS = 4
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       en,
    input  logic       right0,
    input  logic       left0,
    input  logic       right1,
    input  logic       left1,
    output logic [1:0] steer0,
    output logic [1:0] steer1,
    output logic       step0,
    output logic       step1
);
    typedef enum logic [1:0] {
        DIR_HOLD  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_LEFT  = 2'd2
    } dir_e;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_P2   = 1'b1
    } slot_e;

    localparam int unsigned PW     = $clog2(CLKDIV);
    localparam logic [PW-1:0] RELOAD = PW'(CLKDIV - 1);
    localparam logic [3:0]    RAMP   = 4'(RAMP_STEPS);

    logic [PW-1:0] presc_q, presc_d;
    slot_e         slot_q, slot_d;
    dir_e          dir_q     [2];
    dir_e          dir_d     [2];
    dir_e          req       [2];
    logic [1:0]    level_q   [2];
    logic [1:0]    level_d   [2];
    logic [1:0]    sub_q     [2];
    logic [1:0]    sub_d     [2];
    logic [3:0]    stepcnt_q [2];
    logic [3:0]    stepcnt_d [2];
    logic [1:0]    phase_q   [2];
    logic [1:0]    phase_d   [2];
    logic          step_q    [2];
    logic          step_d    [2];
    logic          tick;
    logic [1:0]    svc;
    logic [1:0]    right_v, left_v;

    function automatic dir_e decode(input logic r, input logic l);
        if (r && !l)      return DIR_RIGHT;
        else if (l && !r) return DIR_LEFT;
        else              return DIR_HOLD;
    endfunction

    // Gray sequence 00->01->11->10 for RIGHT, reversed for LEFT
    function automatic logic [1:0] next_phase(input logic [1:0] ph, input dir_e d);
        logic [1:0] nxt;
        nxt = 2'b00;
        if (d == DIR_RIGHT) begin
            case (ph)
                2'b00:   nxt = 2'b01;
                2'b01:   nxt = 2'b11;
                2'b11:   nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end else begin
            case (ph)
                2'b00:   nxt = 2'b10;
                2'b10:   nxt = 2'b11;
                2'b11:   nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

    assign right_v = {right1, right0};
    assign left_v  = {left1, left0};

    always_comb begin
        tick    = en && (presc_q == '0);
        presc_d = presc_q;
        slot_d  = slot_q;
        if (en) presc_d = (presc_q == '0) ? RELOAD : presc_q - 1'b1;
        if (tick)                          slot_d = SLOT_P2;
        else if (en && slot_q == SLOT_P2)  slot_d = SLOT_IDLE;
        svc[0] = tick;
        svc[1] = en && (slot_q == SLOT_P2);

        for (int unsigned p = 0; p < 2; p++) begin
            req[p]       = decode(right_v[p], left_v[p]);
            dir_d[p]     = dir_q[p];
            level_d[p]   = level_q[p];
            sub_d[p]     = sub_q[p];
            stepcnt_d[p] = stepcnt_q[p];
            phase_d[p]   = phase_q[p];
            step_d[p]    = 1'b0;
            if (svc[p]) begin
                if (req[p] == DIR_HOLD) begin
                    dir_d[p]     = DIR_HOLD;
                    level_d[p]   = '0;
                    sub_d[p]     = '0;
                    stepcnt_d[p] = '0;
                end else if (req[p] != dir_q[p]) begin
                    // a fresh direction counts this service as its first interval tick
                    dir_d[p]     = req[p];
                    level_d[p]   = '0;
                    sub_d[p]     = 2'd1;
                    stepcnt_d[p] = '0;
                end else if (({1'b0, sub_q[p]} + 3'd1) == (3'd4 - {1'b0, level_q[p]})) begin
                    sub_d[p]   = '0;
                    step_d[p]  = 1'b1;
                    phase_d[p] = next_phase(phase_q[p], req[p]);
                    if (level_q[p] != 2'd3) begin
                        if ((stepcnt_q[p] + 4'd1) == RAMP) begin
                            level_d[p]   = level_q[p] + 2'd1;
                            stepcnt_d[p] = '0;
                        end else begin
                            stepcnt_d[p] = stepcnt_q[p] + 4'd1;
                        end
                    end
                end else begin
                    sub_d[p] = sub_q[p] + 2'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            presc_q <= RELOAD;
            slot_q  <= SLOT_IDLE;
            for (int unsigned p = 0; p < 2; p++) begin
                dir_q[p]     <= DIR_HOLD;
                level_q[p]   <= '0;
                sub_q[p]     <= '0;
                stepcnt_q[p] <= '0;
                phase_q[p]   <= '0;
                step_q[p]    <= 1'b0;
            end
        end else begin
            presc_q <= presc_d;
            slot_q  <= slot_d;
            for (int unsigned p = 0; p < 2; p++) begin
                dir_q[p]     <= dir_d[p];
                level_q[p]   <= level_d[p];
                sub_q[p]     <= sub_d[p];
                stepcnt_q[p] <= stepcnt_d[p];
                phase_q[p]   <= phase_d[p];
                step_q[p]    <= step_d[p];
            end
        end
    end

    assign steer0 = phase_q[0];
    assign steer1 = phase_q[1];
    assign step0  = step_q[0];
    assign step1  = step_q[1];
endmodule
